mmu_page_engine: RTL and testbench

Page-allocation core that sits between the four request/response FIFOs of the MMU top level, in place of the dummy MMU. It pops alloc and free requests from the request FIFOs and tracks page ownership in a register bitmap. Alloc requests use aligned first-fit placement; frees are validated before release. Results are written into the alloc and free response FIFOs.

---
 rtl/mmu_page_engine_if.sv | 50 +++++
 rtl/mmu_page_engine.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mmu_page_engine.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_page_engine_if.sv
// FIFO-side bundle of the page-allocation engine: request pops, response writes and status.
interface mmu_page_engine_if #(
  parameter int ID_W       = 13,
  parameter int PAGE_IDX_W = 15,
  parameter int SIZE_W     = 4,
  parameter int FAIL_W     = 2
);
  logic                  alloc_fifo_empty;
  logic                  alloc_req_pop;
  logic [ID_W-1:0]       alloc_req_id;
  logic [SIZE_W-1:0]     alloc_req_page_count;
  logic                  free_fifo_empty;
  logic                  free_req_pop;
  logic [ID_W-1:0]       free_req_id;
  logic [PAGE_IDX_W-1:0] free_req_page_idx;
  logic [SIZE_W-1:0]     free_req_page_count;
  logic                  alloc_rsp_fifo_full;
  logic                  free_rsp_fifo_full;
  logic                  alloc_rsp_write_en;
  logic [ID_W-1:0]       alloc_rsp_id;
  logic [PAGE_IDX_W-1:0] alloc_rsp_page_idx;
  logic                  alloc_rsp_fail;
  logic [FAIL_W-1:0]     alloc_rsp_fail_reason;
  logic                  free_rsp_write_en;
  logic [ID_W-1:0]       free_rsp_id;
  logic                  free_rsp_fail;
  logic [FAIL_W-1:0]     free_rsp_fail_reason;
  logic [PAGE_IDX_W:0]   free_page_count;
  logic                  busy;

  modport master (
    input  alloc_fifo_empty, alloc_req_id, alloc_req_page_count,
    input  free_fifo_empty, free_req_id, free_req_page_idx, free_req_page_count,
    input  alloc_rsp_fifo_full, free_rsp_fifo_full,
    output alloc_req_pop, free_req_pop,
    output alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    output free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
    output free_page_count, busy
  );

  modport slave (
    output alloc_fifo_empty, alloc_req_id, alloc_req_page_count,
    output free_fifo_empty, free_req_id, free_req_page_idx, free_req_page_count,
    output alloc_rsp_fifo_full, free_rsp_fifo_full,
    input  alloc_req_pop, free_req_pop,
    input  alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    input  free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
    input  free_page_count, busy
  );
endinterface

// File: rtl/mmu_page_engine.sv
// Page-allocation engine: serves one alloc/free request at a time against a page bitmap,
// using aligned first-fit placement for allocs and full ownership validation for frees.
module mmu_page_engine #(
  parameter int ID_W       = 13,
  parameter int PAGE_IDX_W = 15,
  parameter int SIZE_W     = 4,
  parameter int FAIL_W     = 2,
  parameter int NUM_PAGES  = 256
) (
  input logic               clk,
  input logic               rst_n,
  mmu_page_engine_if.master bus
);
  localparam int NUM_BLOCKS = NUM_PAGES / 8;
  localparam int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int CNT_W      = PAGE_IDX_W + 1;

  localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [FAIL_W-1:0] FAIL_NONE = FAIL_W'(0);
  localparam logic [FAIL_W-1:0] BAD_SIZE  = FAIL_W'(1);
  localparam logic [FAIL_W-1:0] NO_SPACE  = FAIL_W'(2);
  localparam logic [FAIL_W-1:0] BAD_ADDR  = FAIL_W'(3);

  typedef enum logic [2:0] {IDLE, LATCH, SCAN, CHECK, RSP} state_t;

  state_t                state_q, state_d;
  logic                  isAlloc_q, isAlloc_d;
  logic                  lastAlloc_q, lastAlloc_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [PAGE_IDX_W-1:0] idx_q, idx_d;
  logic [3:0]            size_q, size_d;
  logic [7:0]            runMask_q, runMask_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic [NUM_PAGES-1:0]  bitmap_q, bitmap_d;
  logic [CNT_W-1:0]      freeCnt_q, freeCnt_d;
  logic                  allocPop_q, allocPop_d;
  logic                  freePop_q, freePop_d;
  logic                  allocWr_q, allocWr_d;
  logic                  freeWr_q, freeWr_d;
  logic                  busy_q, busy_d;
  logic [ID_W-1:0]       allocId_q, allocId_d;
  logic [PAGE_IDX_W-1:0] allocIdx_q, allocIdx_d;
  logic                  allocFail_q, allocFail_d;
  logic [FAIL_W-1:0]     allocReason_q, allocReason_d;
  logic [ID_W-1:0]       freeId_q, freeId_d;
  logic                  freeFail_q, freeFail_d;
  logic [FAIL_W-1:0]     freeReason_q, freeReason_d;

  logic [7:0]            blkBits;
  logic                  scanHit;
  logic [2:0]            scanOff;
  logic [NUM_PAGES-1:0]  runMaskWide, allocMask, freeMask;
  logic [PAGE_IDX_W-1:0] hitIdx;
  logic [CNT_W:0]        freeEnd;
  logic                  freeOk;
  logic                  doneValid, doneFail;
  logic [FAIL_W-1:0]     doneReason;
  logic [PAGE_IDX_W-1:0] doneIdx;

  // Rounds a page count up to a power-of-two run; 0 marks an unsupported count.
  function automatic logic [3:0] alignSize(input logic [SIZE_W-1:0] count);
    int c;
    c = int'(count);
    if (c == 1)      return 4'd1;
    else if (c == 2) return 4'd2;
    else if (c >= 3 && c <= 4) return 4'd4;
    else if (c >= 5 && c <= 8) return 4'd8;
    else             return 4'd0;
  endfunction

  function automatic logic [7:0] sizeMask(input logic [3:0] s);
    case (s)
      4'd1:    return 8'h01;
      4'd2:    return 8'h03;
      4'd4:    return 8'h0F;
      4'd8:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Lowest aligned free run inside the current 8-page block; the descending loop leaves the lowest hit.
  always_comb begin
    blkBits = bitmap_q[int'(blk_q) * 8 +: 8];
    scanHit = 1'b0;
    scanOff = 3'd0;
    for (int off = 7; off >= 0; off--) begin
      if (((off & (int'(size_q) - 1)) == 0) && ((off + int'(size_q)) <= 8) &&
          ((blkBits & (runMask_q << off)) == 8'h00)) begin
        scanHit = 1'b1;
        scanOff = 3'(off);
      end
    end
  end

  always_comb begin
    runMaskWide = {{(NUM_PAGES-8){1'b0}}, runMask_q};
    hitIdx      = PAGE_IDX_W'({blk_q, scanOff});
    allocMask   = runMaskWide << hitIdx;
    freeMask    = runMaskWide << idx_q;
    freeEnd     = (CNT_W+1)'(idx_q) + (CNT_W+1)'(size_q);
    freeOk      = (freeEnd <= (CNT_W+1)'(NUM_PAGES)) &&
                  ((idx_q & (PAGE_IDX_W'(size_q) - PAGE_IDX_W'(1))) == '0) &&
                  ((bitmap_q & freeMask) == freeMask);
  end

  always_comb begin
    state_d       = state_q;
    isAlloc_d     = isAlloc_q;
    lastAlloc_d   = lastAlloc_q;
    id_d          = id_q;
    idx_d         = idx_q;
    size_d        = size_q;
    runMask_d     = runMask_q;
    blk_d         = blk_q;
    bitmap_d      = bitmap_q;
    freeCnt_d     = freeCnt_q;
    allocPop_d    = 1'b0;
    freePop_d     = 1'b0;
    allocWr_d     = 1'b0;
    freeWr_d      = 1'b0;
    allocId_d     = allocId_q;
    allocIdx_d    = allocIdx_q;
    allocFail_d   = allocFail_q;
    allocReason_d = allocReason_q;
    freeId_d      = freeId_q;
    freeFail_d    = freeFail_q;
    freeReason_d  = freeReason_q;
    doneValid     = 1'b0;
    doneFail      = 1'b0;
    doneReason    = FAIL_NONE;
    doneIdx       = '0;

    unique case (state_q)
      IDLE: begin
        if (allocPop_q || freePop_q) begin
          state_d = LATCH;
        end else if (!bus.alloc_fifo_empty && (bus.free_fifo_empty || !lastAlloc_q)) begin
          allocPop_d  = 1'b1;
          isAlloc_d   = 1'b1;
          lastAlloc_d = 1'b1;
        end else if (!bus.free_fifo_empty) begin
          freePop_d   = 1'b1;
          isAlloc_d   = 1'b0;
          lastAlloc_d = 1'b0;
        end
      end
      LATCH: begin
        id_d      = isAlloc_q ? bus.alloc_req_id : bus.free_req_id;
        idx_d     = bus.free_req_page_idx;
        size_d    = alignSize(isAlloc_q ? bus.alloc_req_page_count : bus.free_req_page_count);
        runMask_d = sizeMask(size_d);
        blk_d     = '0;
        if (size_d == 4'd0) begin
          doneValid  = 1'b1;
          doneFail   = 1'b1;
          doneReason = BAD_SIZE;
        end else begin
          state_d = isAlloc_q ? SCAN : CHECK;
        end
      end
      SCAN: begin
        if (scanHit) begin
          bitmap_d  = bitmap_q | allocMask;
          freeCnt_d = freeCnt_q - CNT_W'(size_q);
          doneValid = 1'b1;
          doneIdx   = hitIdx;
        end else if (blk_q == LAST_BLK) begin
          doneValid  = 1'b1;
          doneFail   = 1'b1;
          doneReason = NO_SPACE;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      CHECK: begin
        doneValid = 1'b1;
        if (freeOk) begin
          bitmap_d  = bitmap_q & ~freeMask;
          freeCnt_d = freeCnt_q + CNT_W'(size_q);
        end else begin
          doneFail   = 1'b1;
          doneReason = BAD_ADDR;
        end
      end
      RSP: begin
        if (allocWr_q || freeWr_q) begin
          state_d = IDLE;
        end else if (isAlloc_q) begin
          allocWr_d = !bus.alloc_rsp_fifo_full;
        end else begin
          freeWr_d = !bus.free_rsp_fifo_full;
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished request loads its response and tries to write it straight away.
    if (doneValid) begin
      state_d = RSP;
      if (isAlloc_q) begin
        allocWr_d     = !bus.alloc_rsp_fifo_full;
        allocId_d     = id_d;
        allocIdx_d    = doneIdx;
        allocFail_d   = doneFail;
        allocReason_d = doneReason;
      end else begin
        freeWr_d     = !bus.free_rsp_fifo_full;
        freeId_d     = id_d;
        freeFail_d   = doneFail;
        freeReason_d = doneReason;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      isAlloc_q     <= 1'b0;
      lastAlloc_q   <= 1'b0;
      id_q          <= '0;
      idx_q         <= '0;
      size_q        <= '0;
      runMask_q     <= '0;
      blk_q         <= '0;
      bitmap_q      <= '0;
      freeCnt_q     <= CNT_W'(NUM_PAGES);
      allocPop_q    <= 1'b0;
      freePop_q     <= 1'b0;
      allocWr_q     <= 1'b0;
      freeWr_q      <= 1'b0;
      busy_q        <= 1'b0;
      allocId_q     <= '0;
      allocIdx_q    <= '0;
      allocFail_q   <= 1'b0;
      allocReason_q <= '0;
      freeId_q      <= '0;
      freeFail_q    <= 1'b0;
      freeReason_q  <= '0;
    end else begin
      state_q       <= state_d;
      isAlloc_q     <= isAlloc_d;
      lastAlloc_q   <= lastAlloc_d;
      id_q          <= id_d;
      idx_q         <= idx_d;
      size_q        <= size_d;
      runMask_q     <= runMask_d;
      blk_q         <= blk_d;
      bitmap_q      <= bitmap_d;
      freeCnt_q     <= freeCnt_d;
      allocPop_q    <= allocPop_d;
      freePop_q     <= freePop_d;
      allocWr_q     <= allocWr_d;
      freeWr_q      <= freeWr_d;
      busy_q        <= busy_d;
      allocId_q     <= allocId_d;
      allocIdx_q    <= allocIdx_d;
      allocFail_q   <= allocFail_d;
      allocReason_q <= allocReason_d;
      freeId_q      <= freeId_d;
      freeFail_q    <= freeFail_d;
      freeReason_q  <= freeReason_d;
    end
  end

  assign bus.alloc_req_pop         = allocPop_q;
  assign bus.free_req_pop          = freePop_q;
  assign bus.alloc_rsp_write_en    = allocWr_q;
  assign bus.alloc_rsp_id          = allocId_q;
  assign bus.alloc_rsp_page_idx    = allocIdx_q;
  assign bus.alloc_rsp_fail        = allocFail_q;
  assign bus.alloc_rsp_fail_reason = allocReason_q;
  assign bus.free_rsp_write_en     = freeWr_q;
  assign bus.free_rsp_id           = freeId_q;
  assign bus.free_rsp_fail         = freeFail_q;
  assign bus.free_rsp_fail_reason  = freeReason_q;
  assign bus.free_page_count       = freeCnt_q;
  assign bus.busy                  = busy_q;
endmodule

// File: tb/tb_mmu_page_engine.sv
// Scoreboard bench for mmu_page_engine: FIFO models feed directed requests, a monitor checks responses.
`timescale 1ns/1ps
module tb_mmu_page_engine;
  localparam int ID_W = 13, PAGE_IDX_W = 15, SIZE_W = 4, FAIL_W = 2, NUM_PAGES = 256;

  typedef struct {
    logic [ID_W-1:0]       id;
    logic [SIZE_W-1:0]     count;
    logic [PAGE_IDX_W-1:0] idx;
  } req_t;

  typedef struct {
    logic [ID_W-1:0]       id;
    logic [PAGE_IDX_W-1:0] idx;
    logic                  fail;
    logic [FAIL_W-1:0]     reason;
    int                    lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   cycle = 0;
  int   allocPops = 0, freePops = 0, allocPopCycle = 0, freePopCycle = 0;
  int   allocWrites = 0;
  req_t allocReqQ[$], freeReqQ[$];
  exp_t allocExpQ[$], freeExpQ[$];

  mmu_page_engine_if #(.ID_W(ID_W), .PAGE_IDX_W(PAGE_IDX_W), .SIZE_W(SIZE_W), .FAIL_W(FAIL_W)) bus ();

  mmu_page_engine #(
    .ID_W(ID_W), .PAGE_IDX_W(PAGE_IDX_W), .SIZE_W(SIZE_W), .FAIL_W(FAIL_W), .NUM_PAGES(NUM_PAGES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit isAlloc, input int id, input int count, input int idx,
                               input bit expFail, input int expReason, input int expIdx, input int expLat);
    req_t r;
    exp_t e;
    r.id     = ID_W'(id);
    r.count  = SIZE_W'(count);
    r.idx    = PAGE_IDX_W'(idx);
    e.id     = ID_W'(id);
    e.idx    = PAGE_IDX_W'(expIdx);
    e.fail   = expFail;
    e.reason = FAIL_W'(expReason);
    e.lat    = expLat;
    if (isAlloc) begin
      allocReqQ.push_back(r);
      allocExpQ.push_back(e);
    end else begin
      freeReqQ.push_back(r);
      freeExpQ.push_back(e);
    end
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (((allocReqQ.size() + freeReqQ.size() + allocExpQ.size() + freeExpQ.size()) != 0 || bus.busy)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: still busy after %0d cycles, expected idle", name, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    allocReqQ.delete();
    freeReqQ.delete();
    allocExpQ.delete();
    freeExpQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Request FIFO models: a pop seen in cycle T presents the head entry for cycle T+1.
  always @(negedge clk) begin : fifoModel
    req_t r;
    if (bus.alloc_req_pop) begin
      checkOutput("alloc pop exclusive",
                  32'({bus.free_req_pop, bus.alloc_rsp_write_en, bus.free_rsp_write_en}), 32'd0);
      allocPops++;
      allocPopCycle = cycle;
      if (allocReqQ.size() > 0) begin
        r = allocReqQ.pop_front();
        bus.alloc_req_id         = r.id;
        bus.alloc_req_page_count = r.count;
      end
    end
    if (bus.free_req_pop) begin
      checkOutput("free pop exclusive",
                  32'({bus.alloc_req_pop, bus.alloc_rsp_write_en, bus.free_rsp_write_en}), 32'd0);
      freePops++;
      freePopCycle = cycle;
      if (freeReqQ.size() > 0) begin
        r = freeReqQ.pop_front();
        bus.free_req_id         = r.id;
        bus.free_req_page_idx   = r.idx;
        bus.free_req_page_count = r.count;
      end
    end
    bus.alloc_fifo_empty = (allocReqQ.size() == 0);
    bus.free_fifo_empty  = (freeReqQ.size() == 0);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.alloc_rsp_write_en) begin
      allocWrites++;
      if (allocExpQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL alloc unexpected: got write id %0d, expected no response", bus.alloc_rsp_id);
      end else begin
        e = allocExpQ.pop_front();
        checkOutput("alloc id", 32'(bus.alloc_rsp_id), 32'(e.id));
        checkOutput("alloc idx", 32'(bus.alloc_rsp_page_idx), 32'(e.idx));
        checkOutput("alloc fail", 32'(bus.alloc_rsp_fail), 32'(e.fail));
        checkOutput("alloc reason", 32'(bus.alloc_rsp_fail_reason), 32'(e.reason));
        if (e.lat >= 0) checkOutput("alloc latency", 32'(cycle - allocPopCycle), 32'(e.lat));
      end
    end
    if (bus.free_rsp_write_en) begin
      if (freeExpQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL free unexpected: got write id %0d, expected no response", bus.free_rsp_id);
      end else begin
        e = freeExpQ.pop_front();
        checkOutput("free id", 32'(bus.free_rsp_id), 32'(e.id));
        checkOutput("free fail", 32'(bus.free_rsp_fail), 32'(e.fail));
        checkOutput("free reason", 32'(bus.free_rsp_fail_reason), 32'(e.reason));
        if (e.lat >= 0) checkOutput("free latency", 32'(cycle - freePopCycle), 32'(e.lat));
      end
    end
  end

  initial begin
    int n;
    int popBase, freeBase, wrBase;
    req_t r;
    bus.alloc_rsp_fifo_full = 1'b0;
    bus.free_rsp_fifo_full  = 1'b0;
    doReset();

    checkOutput("reset alloc pop", 32'(bus.alloc_req_pop), 32'd0);
    checkOutput("reset free pop", 32'(bus.free_req_pop), 32'd0);
    checkOutput("reset alloc wr", 32'(bus.alloc_rsp_write_en), 32'd0);
    checkOutput("reset free wr", 32'(bus.free_rsp_write_en), 32'd0);
    checkOutput("reset alloc rsp", 32'({bus.alloc_rsp_id, bus.alloc_rsp_page_idx}), 32'd0);
    checkOutput("reset alloc fail", 32'({bus.alloc_rsp_fail, bus.alloc_rsp_fail_reason}), 32'd0);
    checkOutput("reset free rsp", 32'({bus.free_rsp_id, bus.free_rsp_fail, bus.free_rsp_fail_reason}), 32'd0);
    checkOutput("reset free count", 32'(bus.free_page_count), 32'd256);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);

    applyStimulus(1, 5, 1, 0, 0, 0, 0, 3);
    waitIdle("single alloc", 50);
    checkOutput("count after alloc 1", 32'(bus.free_page_count), 32'd255);

    applyStimulus(1, 6, 3, 0, 0, 0, 4, 3);
    applyStimulus(1, 7, 8, 0, 0, 0, 8, 4);
    waitIdle("aligned allocs", 80);
    checkOutput("count after aligned allocs", 32'(bus.free_page_count), 32'd243);

    applyStimulus(1, 8, 0, 0, 1, 1, 0, 2);
    applyStimulus(1, 9, 9, 0, 1, 1, 0, 2);
    applyStimulus(0, 10, 0, 0, 1, 1, 0, 2);
    waitIdle("bad size", 80);
    checkOutput("count after bad size", 32'(bus.free_page_count), 32'd243);

    doReset();
    for (int k = 0; k < 32; k++) applyStimulus(1, 100 + k, 8, 0, 0, 0, 8 * k, 3 + k);
    applyStimulus(1, 200, 1, 0, 1, 2, 0, 34);
    waitIdle("fill", 2500);
    checkOutput("count when full", 32'(bus.free_page_count), 32'd0);

    applyStimulus(0, 300, 8, 8, 0, 0, 0, 3);
    waitIdle("good free", 50);
    checkOutput("count after free", 32'(bus.free_page_count), 32'd8);
    applyStimulus(0, 301, 8, 8, 1, 3, 0, 3);
    applyStimulus(0, 302, 4, 2, 1, 3, 0, 3);
    applyStimulus(0, 303, 1, 256, 1, 3, 0, 3);
    waitIdle("bad frees", 80);
    checkOutput("count after bad frees", 32'(bus.free_page_count), 32'd8);
    applyStimulus(1, 304, 8, 0, 0, 0, 8, 4);
    waitIdle("realloc", 80);
    checkOutput("count after realloc", 32'(bus.free_page_count), 32'd0);

    // Arbitration with a stalled alloc response: alloc, then free, then alloc again.
    doReset();
    popBase  = allocPops;
    freeBase = freePops;
    wrBase   = allocWrites;
    bus.alloc_rsp_fifo_full = 1'b1;
    applyStimulus(1, 20, 2, 0, 0, 0, 0, -1);
    applyStimulus(0, 21, 1, 0, 0, 0, 0, 3);
    applyStimulus(1, 22, 1, 0, 0, 0, 0, 3);
    repeat (5) @(negedge clk);
    checkOutput("stall alloc pops", 32'(allocPops - popBase), 32'd1);
    checkOutput("stall free pops", 32'(freePops - freeBase), 32'd0);
    checkOutput("stall busy", 32'(bus.busy), 32'd1);
    checkOutput("stall alloc writes", 32'(allocWrites - wrBase), 32'd0);
    bus.alloc_rsp_fifo_full = 1'b0;
    waitIdle("arbitration", 100);
    checkOutput("arb free pops", 32'(freePops - freeBase), 32'd1);
    checkOutput("count after arbitration", 32'(bus.free_page_count), 32'd254);

    // Reset while the alloc is still scanning: no response may follow.
    popBase = allocPops;
    wrBase  = allocWrites;
    r.id    = ID_W'(30);
    r.count = SIZE_W'(8);
    r.idx   = '0;
    allocReqQ.push_back(r);
    n = 0;
    while (allocPops == popBase && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scan alloc popped", 32'(allocPops - popBase), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-scan reset count", 32'(bus.free_page_count), 32'd256);
    checkOutput("mid-scan reset busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("no response after reset", 32'(allocWrites - wrBase), 32'd0);
    checkOutput("idle after reset", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
